dual_fetch_unit: RTL and testbench
==================================

Name: dual_fetch_unit

Overview:
- Dual-issue fetch stage: owns the PC register, generates the two fetch addresses per cycle, drives the branch predictor's lookup PCs, and holds a direct-mapped branch target buffer (BTB).
- Combines BTB hit/target with the predictor's taken/not-taken bits to select the next PC.
- Applies mispredict redirects from the memory stage.
- Registers a fetch packet into the IF/ID boundary for decode.

Parameters:
- RESET_PC, 8'h00, PC loaded on reset.
- BTB_IDX_W, 4, BTB index width; entries = 2**BTB_IDX_W; tag = pc[7:BTB_IDX_W].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and fetch packet (decode backpressure)
- redirect  in  1  mispredict/flush from memory stage
- redirect_pc  in  8  correct PC on redirect
- upd_en1  in  1  resolved branch, slot 1 (memory stage)
- upd_pc1  in  8  PC of resolved branch, slot 1
- upd_taken1  in  1  branch taken, slot 1
- upd_target1  in  8  resolved target, slot 1
- upd_en2, upd_pc2, upd_taken2, upd_target2  in  1/8/1/8  same, slot 2 (younger)
- pred1  in  1  predictor taken bit for bpu_pc1
- pred2  in  1  predictor taken bit for bpu_pc2
- bpu_pc1  out  8  = fetch_pc (combinational from PC reg)
- bpu_pc2  out  8  = fetch_pc+1 mod 256
- imem_addr  out  8  = fetch_pc (imem returns words at addr, addr+1)
- if_pc1, if_pc2  out  8  registered packet PCs
- if_valid1, if_valid2  out  1  registered slot valids
- if_pred_taken1, if_pred_taken2  out  1  registered predicted-taken per slot
- if_pred_target  out  8  registered predicted target (of the taken slot, else 0)

Behaviour:
- Reset (async, reset=0): fetch_pc=RESET_PC; all BTB valid bits=0; if_valid1/2=0, if_pred_taken1/2=0, if_pc1/2=0, if_pred_target=0.
- BTB entry: valid, tag[8-BTB_IDX_W], target[8]. Lookup is combinational for p1=fetch_pc and p2=fetch_pc+1 (wraps 255->0).
- hitN = valid && tag match at index pN[BTB_IDX_W-1:0]. takeN = hitN && predN.
- Next-PC priority, highest first:
  - redirect: fetch_pc<=redirect_pc; packet cleared (if_valid1/2=0, preds 0). Applies even if stall=1.
  - stall (no redirect): fetch_pc and all if_* hold.
  - take1: fetch_pc<=target1; packet {p1 valid, slot2 invalid, if_pred_taken1=1, if_pred_target=target1}.
  - take2: fetch_pc<=target2; packet {both valid, if_pred_taken2=1, if_pred_target=target2}.
  - otherwise: fetch_pc<=fetch_pc+2 mod 256; both slots valid, no preds, target 0.
- Latency: packet for a fetch_pc appears on if_* the cycle after that fetch_pc is presented. Predictor outputs are consumed in the same cycle as bpu_pc*.
- BTB update, at posedge, independent of stall/redirect:
  - An update port allocates/overwrites its entry only when upd_enN && upd_takenN: valid=1, tag, target.
  - Not-taken updates never modify the BTB.
  - Both ports writing the same index: port 2 wins.
- Update vs lookup in the same cycle: lookup sees pre-update contents (write takes effect next cycle).
- 8-bit wrap on all PC arithmetic. No exceptions or alignment checks.
- Reset asserted mid-operation: immediate return to reset state, BTB contents discarded.

Test Plan:
- Reset, then free-run with empty BTB: fetch_pc 00,02,04…; cycle 2 shows if_pc1=00, if_pc2=01, both valid. Preload RESET_PC=FE: packets FE/FF then 00/01 (wrap).
- Update port1 (pc=04, taken, target=20), then fetch 04 with pred1=1: next fetch_pc=20, packet if_valid2=0, if_pred_taken1=1, if_pred_target=20. Same with pred1=0: next fetch_pc=06, no pred.
- BTB entry at 07 -> 30, fetch 06 with pred2=1, pred1=0: both slots valid, if_pred_taken2=1, next fetch_pc=30.
- Tag alias: entry for 04 -> 20, fetch 14 (same index, different tag) with pred1=1: no hit, next fetch_pc=16.
- stall=1 and redirect=1 (redirect_pc=40) together: next fetch_pc=40, packet invalid. stall alone for 3 cycles: fetch_pc and if_* unchanged.
- Dual update: upd_pc1=05->10 and upd_pc2=15->50, both taken, same index 5: entry tag=1, target=50. Fetch at 15 with pred1=1 redirects to 50. upd_taken=0 leaves the prior entry intact.

Source files
------------

// File: rtl/dual_fetch_unit.sv
// Dual-issue fetch stage: PC register, two fetch addresses per cycle, direct-mapped BTB
// and the registered IF/ID fetch packet.
module dual_fetch_unit #(
   parameter logic [7:0] RESET_PC  = 8'h00,
   parameter int         BTB_IDX_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   input  logic       upd_en1,
   input  logic [7:0] upd_pc1,
   input  logic       upd_taken1,
   input  logic [7:0] upd_target1,
   input  logic       upd_en2,
   input  logic [7:0] upd_pc2,
   input  logic       upd_taken2,
   input  logic [7:0] upd_target2,
   input  logic       pred1,
   input  logic       pred2,
   output logic [7:0] bpu_pc1,
   output logic [7:0] bpu_pc2,
   output logic [7:0] imem_addr,
   output logic [7:0] if_pc1,
   output logic [7:0] if_pc2,
   output logic       if_valid1,
   output logic       if_valid2,
   output logic       if_pred_taken1,
   output logic       if_pred_taken2,
   output logic [7:0] if_pred_target
);

   localparam int N     = 1 << BTB_IDX_W;
   localparam int TAG_W = 8 - BTB_IDX_W;

   logic [7:0]       fetch_pc_q, fetch_pc_d;
   logic [N-1:0]     btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0] btb_tag_q [N];
   logic [TAG_W-1:0] btb_tag_d [N];
   logic [7:0]       btb_tgt_q [N];
   logic [7:0]       btb_tgt_d [N];

   logic [7:0] if_pc1_q, if_pc1_d, if_pc2_q, if_pc2_d, if_tgt_q, if_tgt_d;
   logic       if_v1_q, if_v1_d, if_v2_q, if_v2_d;
   logic       if_t1_q, if_t1_d, if_t2_q, if_t2_d;

   logic [7:0]           p1, p2;
   logic [BTB_IDX_W-1:0] idx1, idx2, uidx1, uidx2;
   logic                 hit1, hit2, take1, take2;

   assign p1    = fetch_pc_q;
   assign p2    = fetch_pc_q + 8'd1;
   assign idx1  = p1[BTB_IDX_W-1:0];
   assign idx2  = p2[BTB_IDX_W-1:0];
   assign uidx1 = upd_pc1[BTB_IDX_W-1:0];
   assign uidx2 = upd_pc2[BTB_IDX_W-1:0];

   // Lookup reads the registered BTB, so same-cycle updates are seen next cycle.
   assign hit1  = btb_valid_q[idx1] && (btb_tag_q[idx1] == p1[7:BTB_IDX_W]);
   assign hit2  = btb_valid_q[idx2] && (btb_tag_q[idx2] == p2[7:BTB_IDX_W]);
   assign take1 = hit1 && pred1;
   assign take2 = hit2 && pred2;

   assign bpu_pc1   = p1;
   assign bpu_pc2   = p2;
   assign imem_addr = p1;

   // stall is decode backpressure: while high (and no redirect) PC and packet hold;
   // redirect overrides stall and flushes the packet.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if_pc1_d   = if_pc1_q;
      if_pc2_d   = if_pc2_q;
      if_v1_d    = if_v1_q;
      if_v2_d    = if_v2_q;
      if_t1_d    = if_t1_q;
      if_t2_d    = if_t2_q;
      if_tgt_d   = if_tgt_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         if_v1_d    = 1'b0;
         if_v2_d    = 1'b0;
         if_t1_d    = 1'b0;
         if_t2_d    = 1'b0;
         if_tgt_d   = 8'h00;
      end else if (!stall) begin
         if_pc1_d = p1;
         if_pc2_d = p2;
         if_v1_d  = 1'b1;
         if (take1) begin
            fetch_pc_d = btb_tgt_q[idx1];
            if_v2_d    = 1'b0;
            if_t1_d    = 1'b1;
            if_t2_d    = 1'b0;
            if_tgt_d   = btb_tgt_q[idx1];
         end else if (take2) begin
            fetch_pc_d = btb_tgt_q[idx2];
            if_v2_d    = 1'b1;
            if_t1_d    = 1'b0;
            if_t2_d    = 1'b1;
            if_tgt_d   = btb_tgt_q[idx2];
         end else begin
            fetch_pc_d = p1 + 8'd2;
            if_v2_d    = 1'b1;
            if_t1_d    = 1'b0;
            if_t2_d    = 1'b0;
            if_tgt_d   = 8'h00;
         end
      end
   end

   // Port 2 is written last so it wins when both ports hit the same index.
   always_comb begin
      btb_valid_d = btb_valid_q;
      btb_tag_d   = btb_tag_q;
      btb_tgt_d   = btb_tgt_q;
      if (upd_en1 && upd_taken1) begin
         btb_valid_d[uidx1] = 1'b1;
         btb_tag_d[uidx1]   = upd_pc1[7:BTB_IDX_W];
         btb_tgt_d[uidx1]   = upd_target1;
      end
      if (upd_en2 && upd_taken2) begin
         btb_valid_d[uidx2] = 1'b1;
         btb_tag_d[uidx2]   = upd_pc2[7:BTB_IDX_W];
         btb_tgt_d[uidx2]   = upd_target2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q  <= RESET_PC;
         btb_valid_q <= '0;
         for (int i = 0; i < N; i++) begin
            btb_tag_q[i] <= '0;
            btb_tgt_q[i] <= '0;
         end
         if_pc1_q <= 8'h00;
         if_pc2_q <= 8'h00;
         if_v1_q  <= 1'b0;
         if_v2_q  <= 1'b0;
         if_t1_q  <= 1'b0;
         if_t2_q  <= 1'b0;
         if_tgt_q <= 8'h00;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         btb_valid_q <= btb_valid_d;
         btb_tag_q   <= btb_tag_d;
         btb_tgt_q   <= btb_tgt_d;
         if_pc1_q    <= if_pc1_d;
         if_pc2_q    <= if_pc2_d;
         if_v1_q     <= if_v1_d;
         if_v2_q     <= if_v2_d;
         if_t1_q     <= if_t1_d;
         if_t2_q     <= if_t2_d;
         if_tgt_q    <= if_tgt_d;
      end
   end

   assign if_pc1         = if_pc1_q;
   assign if_pc2         = if_pc2_q;
   assign if_valid1      = if_v1_q;
   assign if_valid2      = if_v2_q;
   assign if_pred_taken1 = if_t1_q;
   assign if_pred_taken2 = if_t2_q;
   assign if_pred_target = if_tgt_q;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: directed test-plan steps then random traffic, checked
// against an array-based model of the BTB and next-PC rules.
module tb_dual_fetch_unit;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       stall = 1'b0, redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       upd_en1 = 1'b0, upd_taken1 = 1'b0, upd_en2 = 1'b0, upd_taken2 = 1'b0;
   logic [7:0] upd_pc1 = 8'h00, upd_target1 = 8'h00, upd_pc2 = 8'h00, upd_target2 = 8'h00;
   logic       pred1 = 1'b0, pred2 = 1'b0;

   logic [7:0] bpu_pc1, bpu_pc2, imem_addr, if_pc1, if_pc2, if_pred_target;
   logic       if_valid1, if_valid2, if_pred_taken1, if_pred_taken2;
   logic [7:0] f_bpu_pc1, f_bpu_pc2, f_imem_addr, f_if_pc1, f_if_pc2, f_if_pred_target;
   logic       f_if_valid1, f_if_valid2, f_if_pred_taken1, f_if_pred_taken2;

   int vectors = 0;
   int miscompares = 0;

   // model state
   int m_pc;
   bit m_v [N];
   int m_tag [N];
   int m_tgt [N];
   int e_pc1, e_pc2, e_tgt;
   bit e_v1, e_v2, e_t1, e_t2;

   always #5 clk = ~clk;

   dual_fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .upd_en1(upd_en1), .upd_pc1(upd_pc1), .upd_taken1(upd_taken1), .upd_target1(upd_target1),
      .upd_en2(upd_en2), .upd_pc2(upd_pc2), .upd_taken2(upd_taken2), .upd_target2(upd_target2),
      .pred1(pred1), .pred2(pred2), .bpu_pc1(bpu_pc1), .bpu_pc2(bpu_pc2), .imem_addr(imem_addr),
      .if_pc1(if_pc1), .if_pc2(if_pc2), .if_valid1(if_valid1), .if_valid2(if_valid2),
      .if_pred_taken1(if_pred_taken1), .if_pred_taken2(if_pred_taken2),
      .if_pred_target(if_pred_target)
   );

   dual_fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .upd_en1(upd_en1), .upd_pc1(upd_pc1), .upd_taken1(upd_taken1), .upd_target1(upd_target1),
      .upd_en2(upd_en2), .upd_pc2(upd_pc2), .upd_taken2(upd_taken2), .upd_target2(upd_target2),
      .pred1(pred1), .pred2(pred2), .bpu_pc1(f_bpu_pc1), .bpu_pc2(f_bpu_pc2),
      .imem_addr(f_imem_addr), .if_pc1(f_if_pc1), .if_pc2(f_if_pc2),
      .if_valid1(f_if_valid1), .if_valid2(f_if_valid2),
      .if_pred_taken1(f_if_pred_taken1), .if_pred_taken2(f_if_pred_taken2),
      .if_pred_target(f_if_pred_target)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
      end
      e_pc1 = 0; e_pc2 = 0; e_tgt = 0;
      e_v1 = 0; e_v2 = 0; e_t1 = 0; e_t2 = 0;
   endtask

   task automatic compare_all();
      chk("bpu_pc1", bpu_pc1, 8'(m_pc));
      chk("bpu_pc2", bpu_pc2, 8'((m_pc + 1) % 256));
      chk("imem_addr", imem_addr, 8'(m_pc));
      chk("if_valid1", {7'b0, if_valid1}, {7'b0, e_v1});
      chk("if_valid2", {7'b0, if_valid2}, {7'b0, e_v2});
      chk("if_pred_taken1", {7'b0, if_pred_taken1}, {7'b0, e_t1});
      chk("if_pred_taken2", {7'b0, if_pred_taken2}, {7'b0, e_t2});
      chk("if_pred_target", if_pred_target, 8'(e_tgt));
      if (e_v1) chk("if_pc1", if_pc1, 8'(e_pc1));
      if (e_v2) chk("if_pc2", if_pc2, 8'(e_pc2));
   endtask

   // One cycle: drive inputs, advance the model, clock, compare.
   task automatic step(input bit st, input bit rd, input int rpc,
                       input bit ue1, input int up1, input bit ut1, input int ug1,
                       input bit ue2, input int up2, input bit ut2, input int ug2,
                       input bit pr1, input bit pr2);
      int p1, p2;
      bit h1, h2;
      stall = st; redirect = rd; redirect_pc = 8'(rpc);
      upd_en1 = ue1; upd_pc1 = 8'(up1); upd_taken1 = ut1; upd_target1 = 8'(ug1);
      upd_en2 = ue2; upd_pc2 = 8'(up2); upd_taken2 = ut2; upd_target2 = 8'(ug2);
      pred1 = pr1; pred2 = pr2;
      p1 = m_pc;
      p2 = (m_pc + 1) % 256;
      h1 = m_v[p1 % N] && (m_tag[p1 % N] == p1 / N);
      h2 = m_v[p2 % N] && (m_tag[p2 % N] == p2 / N);
      if (rd) begin
         m_pc = rpc;
         e_v1 = 0; e_v2 = 0; e_t1 = 0; e_t2 = 0; e_tgt = 0;
      end else if (!st) begin
         e_pc1 = p1; e_pc2 = p2; e_v1 = 1;
         if (h1 && pr1) begin
            e_v2 = 0; e_t1 = 1; e_t2 = 0; e_tgt = m_tgt[p1 % N]; m_pc = e_tgt;
         end else if (h2 && pr2) begin
            e_v2 = 1; e_t1 = 0; e_t2 = 1; e_tgt = m_tgt[p2 % N]; m_pc = e_tgt;
         end else begin
            e_v2 = 1; e_t1 = 0; e_t2 = 0; e_tgt = 0; m_pc = (m_pc + 2) % 256;
         end
      end
      if (ue1 && ut1) begin
         m_v[up1 % N] = 1; m_tag[up1 % N] = up1 / N; m_tgt[up1 % N] = ug1;
      end
      if (ue2 && ut2) begin
         m_v[up2 % N] = 1; m_tag[up2 % N] = up2 / N; m_tgt[up2 % N] = ug2;
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input bit pr1, input bit pr2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pr1, pr2);
   endtask

   task automatic go(input int pc);
      step(0, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #7;
      compare_all();
      chk("reset_if_pc1", if_pc1, 8'h00);
      chk("reset_if_pc2", if_pc2, 8'h00);
      chk("fe_reset_pc", f_bpu_pc1, 8'hFE);
      #1 reset = 1'b1;

      // free run from reset, plus the FE instance wrapping
      idle(0, 0);
      chk("run_if_pc1", if_pc1, 8'h00);
      chk("run_if_pc2", if_pc2, 8'h01);
      chk("fe_if_pc1_a", f_if_pc1, 8'hFE);
      chk("fe_if_pc2_a", f_if_pc2, 8'hFF);
      chk("fe_bpu_pc1_a", f_bpu_pc1, 8'h00);
      idle(1, 1);
      chk("fe_if_pc1_b", f_if_pc1, 8'h00);
      chk("fe_if_pc2_b", f_if_pc2, 8'h01);
      chk("fe_valid2_b", {7'b0, f_if_valid2}, 8'h01);
      idle(0, 0);

      // slot-1 hit: 04 -> 20
      step(0, 1, 8'h04, 1, 8'h04, 1, 8'h20, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      chk("take1_pc", bpu_pc1, 8'h20);
      chk("take1_tgt", if_pred_target, 8'h20);
      go(8'h04);
      // predicted not-taken; also install 07 -> 30 for the slot-2 test
      step(0, 0, 0, 0, 0, 0, 0, 1, 8'h07, 1, 8'h30, 0, 0);
      chk("nt_pc", bpu_pc1, 8'h06);
      idle(0, 1);
      chk("take2_pc", bpu_pc1, 8'h30);
      chk("take2_t2", {7'b0, if_pred_taken2}, 8'h01);
      // tag alias at 14
      go(8'h14);
      idle(1, 1);
      chk("alias_pc", bpu_pc1, 8'h16);
      // stall + redirect, then stall alone
      step(1, 1, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("stall_redir_pc", bpu_pc1, 8'h40);
      idle(0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("stall_hold_pc", bpu_pc1, 8'h42);
      // dual update, same index: port 2 wins
      step(0, 1, 8'h15, 1, 8'h05, 1, 8'h10, 1, 8'h15, 1, 8'h50, 0, 0);
      idle(1, 0);
      chk("dual_upd_pc", bpu_pc1, 8'h50);
      // not-taken update leaves the entry intact
      step(0, 1, 8'h15, 1, 8'h15, 0, 8'h77, 0, 0, 0, 0, 0, 0);
      idle(1, 0);
      chk("nt_upd_pc", bpu_pc1, 8'h50);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 63),
              $urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom_range(0, 3) != 0,
              $urandom_range(0, 63),
              $urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom_range(0, 3) != 0,
              $urandom_range(0, 63),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // asynchronous reset mid-cycle discards the BTB
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      #2 reset = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 63),
              $urandom_range(0, 2) == 0, $urandom_range(0, 63), 1'($urandom_range(0, 1)),
              $urandom_range(0, 63),
              $urandom_range(0, 2) == 0, $urandom_range(0, 63), 1'($urandom_range(0, 1)),
              $urandom_range(0, 63),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
